// File: rtl/tt_sel_seq.sv
// tt_sel_seq: drives the ctrl_sel_rst_n / ctrl_sel_inc / ctrl_ena design-selection protocol.
// Optional TT_SEL_SKIP_EN: step forward from the current address instead of resetting the counter.
module tt_sel_seq #(
    parameter int ADDR_W    = 10,
    parameter int RST_CYC   = 4,
    parameter int PULSE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_valid,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              o_req_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_cur_addr,
    output logic              o_ctrl_sel_rst_n,
    output logic              o_ctrl_sel_inc,
    output logic              o_ctrl_ena
);
    localparam int MX = RST_CYC > PULSE_CYC ? RST_CYC : PULSE_CYC;
    localparam int CW = $clog2(MX + 1);

    typedef enum logic [2:0] {S_IDLE, S_DIS, S_RST, S_GAP, S_HI, S_LO} state_t;

    state_t            r_state, w_nxt;
    logic [CW-1:0]     r_cnt;
    logic [ADDR_W-1:0] r_tgt, r_cur;
    logic              r_ready, r_done, r_sel_rst_n, r_inc, r_ena;
    logic              w_accept, w_last_rst, w_last_pul, w_more;

    assign w_accept   = i_req_valid && r_ready;
    assign w_last_rst = r_cnt == CW'(RST_CYC - 1);
    assign w_last_pul = r_cnt == CW'(PULSE_CYC - 1);
    // remaining steps are tracked implicitly as the gap between cur and target
    assign w_more     = r_cur != r_tgt;

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE: w_nxt = w_accept ? S_DIS : S_IDLE;
`ifdef TT_SEL_SKIP_EN
            S_DIS:  w_nxt = r_tgt < r_cur ? S_RST : (w_more ? S_HI : S_IDLE);
`else
            S_DIS:  w_nxt = S_RST;
`endif
            S_RST:  w_nxt = w_last_rst ? S_GAP : S_RST;
            S_GAP:  w_nxt = w_last_pul ? (w_more ? S_HI : S_IDLE) : S_GAP;
            S_HI:   w_nxt = w_last_pul ? S_LO : S_HI;
            S_LO:   w_nxt = w_last_pul ? (w_more ? S_HI : S_IDLE) : S_LO;
            default: w_nxt = S_IDLE;
        endcase
    end

    // outputs are registered from the next state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_tgt       <= '0;
            r_cur       <= '0;
            r_ready     <= 1'b0;
            r_done      <= 1'b0;
            r_sel_rst_n <= 1'b0;
            r_inc       <= 1'b0;
            r_ena       <= 1'b0;
        end else begin
            r_state     <= w_nxt;
            r_cnt       <= (w_nxt != r_state || r_state == S_IDLE) ? '0 : r_cnt + CW'(1);
            if (w_accept) r_tgt <= i_req_addr;
            if (w_nxt == S_RST) r_cur <= '0;
            else if (w_nxt == S_HI && r_state != S_HI) r_cur <= r_cur + ADDR_W'(1);
            r_ready     <= w_nxt == S_IDLE;
            r_done      <= w_nxt == S_IDLE && r_state != S_IDLE;
            r_sel_rst_n <= w_nxt != S_RST;
            r_inc       <= w_nxt == S_HI;
            r_ena       <= w_nxt == S_IDLE && (r_ena || r_state != S_IDLE);
        end
    end

    assign o_req_ready      = r_ready;
    assign o_busy           = !r_ready;
    assign o_done           = r_done;
    assign o_cur_addr       = r_cur;
    assign o_ctrl_sel_rst_n = r_sel_rst_n;
    assign o_ctrl_sel_inc   = r_inc;
    assign o_ctrl_ena       = r_ena;
endmodule

// File: tb/tb_tt_sel_seq.sv
// tb_tt_sel_seq: timeline model of the selection protocol checked every cycle, plus literal spot checks.
module tb_tt_sel_seq;
    localparam int AW = 10;
    localparam int R  = 4;
    localparam int P  = 2;

    logic          clk = 1'b0, rst_n = 1'b0, valid = 1'b0;
    logic [AW-1:0] addr = '0;
    logic          o_req_ready, o_busy, o_done, o_ctrl_sel_rst_n, o_ctrl_sel_inc, o_ctrl_ena;
    logic [AW-1:0] o_cur_addr;
    int            total = 0, bad = 0, cyc = 0, ca = 0, n_inc = 0, n_rst = 0;
    bit            mon_en = 1'b0;

    tt_sel_seq #(.ADDR_W(AW), .RST_CYC(R), .PULSE_CYC(P)) dut (
        .clk(clk), .rst_n(rst_n), .i_req_valid(valid), .i_req_addr(addr),
        .o_req_ready(o_req_ready), .o_busy(o_busy), .o_done(o_done), .o_cur_addr(o_cur_addr),
        .o_ctrl_sel_rst_n(o_ctrl_sel_rst_n), .o_ctrl_sel_inc(o_ctrl_sel_inc), .o_ctrl_ena(o_ctrl_ena)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge o_ctrl_sel_inc) n_inc++;
    always @(negedge o_ctrl_sel_rst_n) n_rst++;

    task automatic chk(string name, logic [31:0] act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at cyc=%0d", name, act, exp, cyc);
        end
    endtask

    // finish cycle offset from the accept cycle for target a starting at c
    function automatic int fin(int a, int c);
`ifdef TT_SEL_SKIP_EN
        if (a >= c) return 2 + 2 * P * (a - c);
`endif
        return 2 + R + P + 2 * P * a;
    endfunction

    bit m_ok = 0, m_act = 0, m_ena = 0;
    int m_k = 0, m_a = 0, m_c = 0, m_cur = 0;
    logic e_rdy, e_ena, e_done, e_inc, e_rstn;
    int   e_cur;

    always_comb begin
        int base, off;
        bit sk;
        base = 0; off = 0; sk = 0;
        e_rdy = m_ok; e_ena = m_ena; e_done = 0; e_inc = 0; e_rstn = m_ok; e_cur = m_cur;
        if (m_act) begin
`ifdef TT_SEL_SKIP_EN
            sk = m_a >= m_c;
`endif
            base = sk ? 2 : 2 + R + P;
            if (m_k == fin(m_a, m_c)) begin
                e_ena = 1; e_done = 1; e_rdy = 1; e_rstn = 1; e_cur = m_a;
            end else begin
                e_rdy = 0; e_ena = 0; e_rstn = 1;
                if (m_k == 1) e_cur = m_c;
                else if (m_k < base) begin
                    e_cur = 0;
                    e_rstn = !(m_k < 2 + R);
                end else begin
                    off = m_k - base;
                    e_inc = (off % (2 * P)) < P;
                    e_cur = (sk ? m_c : 0) + off / (2 * P) + 1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ok <= 0; m_act <= 0; m_ena <= 0; m_k <= 0; m_a <= 0; m_c <= 0; m_cur <= 0;
        end else begin
            m_ok <= 1;
            if (valid && e_rdy) begin
                m_act <= 1; m_k <= 1; m_a <= int'(addr); m_c <= e_cur;
            end else if (m_act) begin
                if (m_k == fin(m_a, m_c)) begin
                    m_act <= 0; m_ena <= 1; m_cur <= m_a;
                end else m_k <= m_k + 1;
            end
        end
    end

    always @(negedge clk) if (mon_en) begin
        chk("ready", o_req_ready, e_rdy);
        chk("busy", o_busy, !e_rdy);
        chk("done", o_done, e_done);
        chk("ena", o_ctrl_ena, e_ena);
        chk("inc", o_ctrl_sel_inc, e_inc);
        chk("sel_rst_n", o_ctrl_sel_rst_n, e_rstn);
        chk("cur_addr", o_cur_addr, e_cur);
    end

    // present a request until accepted; returns #1 after the accepting edge (cycle T+1)
    task automatic req(int a, bit keep);
        bit got = 0;
        @(negedge clk);
        valid = 1; addr = AW'(a);
        for (int i = 0; i < 5000 && !got; i++) begin
            if (o_req_ready) got = 1;
            else @(negedge clk);
        end
        if (!got) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        ca = cyc;
        if (!keep) valid = 0;
    endtask

    task automatic at(int n);
        while (cyc < ca + n - 1) begin @(posedge clk); #1; end
        @(negedge clk);
    endtask

    task automatic wait_done();
        bit got = 0;
        for (int i = 0; i < 5000 && !got; i++) begin
            @(negedge clk);
            if (o_done) got = 1;
        end
        if (!got) chk("done_timeout", 0, 1);
    endtask

    initial begin
        #1 mon_en = 1;
        #21 rst_n = 1;
        @(posedge clk); @(negedge clk);
        chk("rst_ready", o_req_ready, 1);
        chk("rst_sel_rst_n", o_ctrl_sel_rst_n, 1);
        chk("rst_ena", o_ctrl_ena, 0);
        chk("rst_cur", o_cur_addr, 0);

        n_inc = 0; n_rst = 0;
        req(3, 0);
        addr = 7;
        at(1);  chk("t2_ena_low", o_ctrl_ena, 0);
        at(2);  chk("t2_rst_lo_first", o_ctrl_sel_rst_n, 0);
        at(5);  chk("t2_rst_lo_last", o_ctrl_sel_rst_n, 0);
        at(6);  chk("t2_rst_hi", o_ctrl_sel_rst_n, 1);
        at(19); chk("t2_ena_pre", o_ctrl_ena, 0);
        at(20); chk("t2_ena", o_ctrl_ena, 1); chk("t2_done", o_done, 1);
        chk("t2_cur", o_cur_addr, 3); chk("t2_pulses", n_inc, 3);

        n_inc = 0;
        req(0, 0);
        at(8); chk("t3_ena", o_ctrl_ena, 1); chk("t3_cur", o_cur_addr, 0); chk("t3_pulses", n_inc, 0);

        n_inc = 0;
        req(2, 1);
        addr = 5;
        wait_done();
        chk("t4_pulses", n_inc, 2); chk("t4_cur", o_cur_addr, 2);
        n_inc = 0;
        @(negedge clk);
        valid = 0;
        chk("t4_second_dis", o_ctrl_ena, 0); chk("t4_second_busy", o_busy, 1);
        wait_done();
        chk("t4_second_cur", o_cur_addr, 5); chk("t4_second_pulses", n_inc, 5);

        req(3, 0);
        begin
            bit got = 0;
            for (int i = 0; i < 100 && !got; i++) begin
                @(negedge clk);
                if (o_ctrl_sel_inc) got = 1;
            end
            if (!got) chk("t5_inc_timeout", 0, 1);
        end
        #2 rst_n = 0;
        #1 chk("t5_inc", o_ctrl_sel_inc, 0); chk("t5_sel_rst_n", o_ctrl_sel_rst_n, 0);
        chk("t5_ena", o_ctrl_ena, 0); chk("t5_cur", o_cur_addr, 0);
        @(negedge clk); #2 rst_n = 1;
        @(posedge clk); @(negedge clk);
        chk("t5_idle_ready", o_req_ready, 1); chk("t5_idle_cur", o_cur_addr, 0);

        req(3, 0);
        wait_done();
        n_rst = 0; n_inc = 0;
        req(5, 0);
`ifdef TT_SEL_SKIP_EN
        at(9);  chk("t6_ena_pre", o_ctrl_ena, 0);
        at(10); chk("t6_ena", o_ctrl_ena, 1); chk("t6_cur", o_cur_addr, 5);
        chk("t6_no_rst", n_rst, 0); chk("t6_pulses", n_inc, 2);
        req(5, 0);
        at(1); chk("t6_same_dis", o_ctrl_ena, 0);
        at(2); chk("t6_same_ena", o_ctrl_ena, 1); chk("t6_same_done", o_done, 1);
`else
        at(28); chk("t6_ena", o_ctrl_ena, 1); chk("t6_cur", o_cur_addr, 5);
        chk("t6_rst", n_rst, 1); chk("t6_pulses", n_inc, 5);
`endif
        n_rst = 0;
        req(1, 0);
        at(12); chk("t6_back_ena", o_ctrl_ena, 1); chk("t6_back_cur", o_cur_addr, 1);
        chk("t6_back_rst", n_rst, 1);

        req((1 << AW) - 1, 0);
        wait_done();
        chk("max_cur", o_cur_addr, (1 << AW) - 1);
        @(negedge clk);
        chk("max_hold_ena", o_ctrl_ena, 1); chk("max_done_clear", o_done, 0);

        mon_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
